mac_out_stage: RTL and testbench



---
 rtl/mac_pkg.sv | 18 +
 rtl/mac_out_fifo.sv | 65 ++++++
 rtl/mac_out_stage.sv | 121 ++++++++++++
 tb/tb_mac_out_stage.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mac_pkg                                                                |
// | Default geometry and output-range constants for the MAC output stage. |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
package mac_pkg;

    localparam int c_ACC_W   = 20;
    localparam int c_OUT_W   = 8;
    localparam int c_SHIFT   = 4;
    localparam int c_DEPTH   = 4;
    localparam int c_OUT_MAX = 2 ** (c_OUT_W - 1) - 1;
    localparam int c_OUT_MIN = -(2 ** (c_OUT_W - 1));
    localparam int c_PTR_W   = $clog2(c_DEPTH);

endpackage
`default_nettype wire

// File: rtl/mac_out_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mac_out_fifo                                                           |
// | Synchronous FIFO, power-of-two depth; the writer guarantees space.    |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
module mac_out_fifo
    import mac_pkg::*;
#(
    parameter int WIDTH = c_OUT_W,
    parameter int DEPTH = c_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic [PTR_W:0]   o_count,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_pop;

    assign w_pop   = i_pop && !o_empty;
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (PTR_W + 1)'(DEPTH));
    assign o_count = r_count;
    // Empty FIFO presents zero rather than a stale entry.
    assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (i_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !i_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mac_out_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mac_out_stage                                                          |
// | Captures MAC results, rescales/saturates them and queues them in a    |
// | FIFO with slot reservation. Optional macro RELU_EN clamps negatives.  |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
module mac_out_stage
    import mac_pkg::*;
#(
    parameter int ACC_W = c_ACC_W,
    parameter int OUT_W = c_OUT_W,
    parameter int SHIFT = c_SHIFT,
    parameter int DEPTH = c_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mac_done,
    input  logic [ACC_W-1:0] mac_acc,
    output logic             mac_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       sat_cnt,
    output logic             ovf_err
);

    localparam int c_PW = $clog2(DEPTH);
    localparam int c_RW = c_PW + 2;
    localparam logic signed [ACC_W-1:0] c_HI = ACC_W'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [ACC_W-1:0] c_LO = ~c_HI;

    logic signed [ACC_W-1:0] r_s1_acc;
    logic                    r_s1_v;
    logic [OUT_W-1:0]        r_s2_data;
    logic                    r_s2_sat;
    logic                    r_s2_v;
    logic [7:0]              r_sat_cnt;
    logic                    r_ovf_err;

    logic signed [ACC_W-1:0] w_t;
    logic [OUT_W-1:0]        w_res;
    logic                    w_sat;
    logic [c_PW:0]           w_count;
    logic [c_RW-1:0]         w_resv;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_accept;

    // Results still in the pipeline hold a reserved FIFO slot.
    assign w_resv    = c_RW'(w_count) + c_RW'(r_s1_v) + c_RW'(r_s2_v);
    assign mac_ready = !w_full && (w_resv < c_RW'(DEPTH));
    assign w_accept  = mac_done && mac_ready;
    assign out_valid = !w_empty;
    assign sat_cnt   = r_sat_cnt;
    assign ovf_err   = r_ovf_err;

    assign w_t = r_s1_acc >>> SHIFT;

    always_comb begin
        w_sat = 1'b0;
        w_res = w_t[OUT_W-1:0];
        if (w_t > c_HI) begin
            w_res = c_HI[OUT_W-1:0];
            w_sat = 1'b1;
        end else if (w_t < c_LO) begin
            w_res = c_LO[OUT_W-1:0];
            w_sat = 1'b1;
        end
`ifdef RELU_EN
        // Any negative word becomes zero; the saturation flag is kept.
        if (w_res[OUT_W-1]) begin
            w_res = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_acc  <= '0;
            r_s1_v    <= 1'b0;
            r_s2_data <= '0;
            r_s2_sat  <= 1'b0;
            r_s2_v    <= 1'b0;
            r_sat_cnt <= '0;
            r_ovf_err <= 1'b0;
        end else begin
            r_s1_v <= w_accept;
            if (w_accept) begin
                r_s1_acc <= mac_acc;
            end
            r_s2_v    <= r_s1_v;
            r_s2_data <= w_res;
            r_s2_sat  <= w_sat;
            if (r_s2_v && r_s2_sat && (r_sat_cnt != 8'hFF)) begin
                r_sat_cnt <= r_sat_cnt + 8'd1;
            end
            if (mac_done && !mac_ready) begin
                r_ovf_err <= 1'b1;
            end
        end
    end

    mac_out_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (DEPTH),
        .PTR_W (c_PW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_s2_v),
        .i_data  (r_s2_data),
        .i_pop   (out_ready),
        .o_data  (out_data),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

endmodule
`default_nettype wire

// File: tb/tb_mac_out_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mac_out_stage                                                       |
// | Directed self-checking bench for mac_out_stage (default geometry).    |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
module tb_mac_out_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        mac_done;
    logic [19:0] mac_acc;
    logic        out_ready;
    logic        mac_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic [7:0]  sat_cnt;
    logic        ovf_err;

    int n_total = 0;
    int n_bad   = 0;

    mac_out_stage #(
        .ACC_W (20),
        .OUT_W (8),
        .SHIFT (4),
        .DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mac_done  (mac_done),
        .mac_acc   (mac_acc),
        .mac_ready (mac_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sat_cnt   (sat_cnt),
        .ovf_err   (ovf_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [19:0] v);
        mac_done = 1'b1;
        mac_acc  = v;
        tick();
        mac_done = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] exp_neg_sat;
        logic [7:0] exp_neg;
`ifdef RELU_EN
        exp_neg_sat = 8'h00;
        exp_neg     = 8'h00;
`else
        exp_neg_sat = 8'h80;
        exp_neg     = 8'hCE;
`endif
        rst = 1'b1; mac_done = 1'b0; mac_acc = '0; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("rst_valid", out_valid, 1'b0);
        check("rst_data",  out_data,  8'h00);
        check("rst_ready", mac_ready, 1'b1);
        check("rst_sat",   sat_cnt,   8'h00);
        check("rst_ovf",   ovf_err,   1'b0);

        // Basic path: 800 >>> 4 = 50, three-cycle latency, popped at once.
        out_ready = 1'b1;
        pulse(20'd800);
        tick();
        check("lat_T2_valid", out_valid, 1'b0);
        tick();
        check("lat_T3_valid", out_valid, 1'b1);
        check("lat_T3_data",  out_data,  8'h32);
        tick();
        check("pop_empty",    out_valid, 1'b0);
        check("sat_after_50", sat_cnt,   8'd0);

        pulse(20'h7FFFF); tick(); tick();
        check("pos_sat_data", out_data, 8'h7F);
        check("pos_sat_cnt",  sat_cnt,  8'd1);
        tick();

        pulse(20'h80000); tick(); tick();
        check("neg_sat_data", out_data, exp_neg_sat);
        check("neg_sat_cnt",  sat_cnt,  8'd2);
        tick();

        pulse(20'hFFCE0); tick(); tick();
        check("neg_data",     out_data, exp_neg);
        check("neg_sat_cnt2", sat_cnt,  8'd2);
        tick();

        // Reservation: four results fill every slot, fifth is dropped.
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("resv_ready_%0d", i), mac_ready, 1'b1);
            pulse(20'(16 * i));
        end
        check("resv_full_ready", mac_ready, 1'b0);
        check("resv_ovf_pre",    ovf_err,   1'b0);
        pulse(20'd80);
        check("resv_ovf",        ovf_err,   1'b1);
        tick();
        check("resv_head_valid", out_valid, 1'b1);
        check("resv_still_busy", mac_ready, 1'b0);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("drain_valid_%0d", i), out_valid, 1'b1);
            check($sformatf("drain_data_%0d", i),  out_data,  32'(i));
            tick();
        end
        check("drain_empty",  out_valid, 1'b0);
        check("drain_ovf",    ovf_err,   1'b1);

        // Wrap and simultaneous push/pop while three entries are stored.
        out_ready = 1'b0;
        for (int i = 10; i <= 13; i++) begin
            pulse(20'(16 * i));
        end
        tick(); tick();
        check("wrap_full_ready", mac_ready, 1'b0);
        check("wrap_head0",      out_data,  8'd10);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("wrap_freed_ready", mac_ready, 1'b1);
        check("wrap_head1",       out_data,  8'd11);
        pulse(20'(16 * 14));
        tick();
        check("wrap_reserved", mac_ready, 1'b0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("pushpop_ready", mac_ready, 1'b1);
        check("pushpop_head",  out_data,  8'd12);
        out_ready = 1'b1;
        for (int i = 12; i <= 14; i++) begin
            check($sformatf("wrap_valid_%0d", i), out_valid, 1'b1);
            check($sformatf("wrap_data_%0d", i),  out_data,  32'(i));
            tick();
        end
        check("wrap_empty", out_valid, 1'b0);

        // Reset mid-flight with two entries queued and one in stage 1.
        out_ready = 1'b0;
        pulse(20'd32);
        pulse(20'd48);
        tick(); tick();
        check("pre_rst_valid", out_valid, 1'b1);
        pulse(20'd64);
        rst = 1'b1; mac_done = 1'b1; mac_acc = 20'd96;
        tick();
        rst = 1'b0; mac_done = 1'b0;
        check("post_rst_valid", out_valid, 1'b0);
        check("post_rst_ready", mac_ready, 1'b1);
        check("post_rst_sat",   sat_cnt,   8'd0);
        check("post_rst_ovf",   ovf_err,   1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("post_rst_quiet_%0d", i), out_valid, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
